// File: rtl/nv_ram_fifo_ctl_512x64.sv
// Controller for a 512x64 FIFO built on an external synchronous-read RAM.
// Keeps one popped-side output slot (rd_pvld) fed by a one-cycle read pipeline.
module nv_ram_fifo_ctl_512x64 (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [63:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [63:0] rd_pd,
    output logic        ram_we,
    output logic [8:0]  ram_wa,
    output logic [63:0] ram_di,
    output logic        ram_re,
    output logic [8:0]  ram_ra,
    input  logic [63:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd,
    output logic [9:0]  fifo_count,
    output logic        fifo_idle
);

    localparam logic [9:0] DEPTH = 10'd512;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and wr_prdy depends only on registered count.

    logic [8:0] wr_ptr_q, wr_ptr_d;
    logic [8:0] rd_ptr_q, rd_ptr_d;
    logic [9:0] count_q, count_d;
    logic       rd_pvld_q, rd_pvld_d;
    logic       push, pop, read_issue;
    logic [9:0] unread;

    always_comb begin
        wr_prdy    = (count_q != DEPTH);
        push       = wr_pvld && wr_prdy && nvdla_core_rstn;
        pop        = rd_pvld_q && rd_prdy;
        // count includes the entry already presented on rd_pd
        unread     = count_q - {9'd0, rd_pvld_q};
        read_issue = (unread != 10'd0) && (!rd_pvld_q || rd_prdy);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_pvld_d = rd_pvld_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 9'd1;
        end
        if (read_issue) begin
            rd_ptr_d = rd_ptr_q + 9'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 10'd1;
            2'b01:   count_d = count_q - 10'd1;
            default: count_d = count_q;
        endcase

        if (read_issue) begin
            rd_pvld_d = 1'b1;
        end else if (pop) begin
            rd_pvld_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q  <= 9'd0;
            rd_ptr_q  <= 9'd0;
            count_q   <= 10'd0;
            rd_pvld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pvld_q <= rd_pvld_d;
        end
    end

    always_comb begin
        ram_we            = push;
        ram_wa            = wr_ptr_q;
        ram_di            = wr_pd;
        ram_re            = read_issue;
        ram_ra            = rd_ptr_q;
        rd_pvld           = rd_pvld_q;
        rd_pd             = ram_dout;
        fifo_count        = count_q;
        fifo_idle         = (count_q == 10'd0) && !wr_pvld;
        ram_pwrbus_ram_pd = pwrbus_ram_pd;
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctl_512x64.sv
// Directed bench for nv_ram_fifo_ctl_512x64 with a behavioural 512x64 RAM
// and a queue scoreboard watching every push and pop.
module tb_nv_ram_fifo_ctl_512x64;

    logic        clk;
    logic        rst_n;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [63:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [63:0] rd_pd;
    logic        ram_we;
    logic [8:0]  ram_wa;
    logic [63:0] ram_di;
    logic        ram_re;
    logic [8:0]  ram_ra;
    logic [63:0] ram_dout;
    logic [31:0] pwrbus_ram_pd;
    logic [31:0] ram_pwrbus_ram_pd;
    logic [9:0]  fifo_count;
    logic        fifo_idle;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    nv_ram_fifo_ctl_512x64 dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rst_n),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
        .fifo_count        (fifo_count),
        .fifo_idle         (fifo_idle)
    );

    // Clock and RAM model: registered read address, data valid the cycle after ram_re.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [512];
    logic [8:0]  ra_q;
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'hBAD0_0000_0000_0000 | 64'(i);
        ra_q = 9'd0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int k = 0; k < limit && fifo_count != 10'd0; k++) tick();
        check("drain_count", 64'(fifo_count), 64'd0);
        check("drain_rd_pvld", 64'(rd_pvld), 64'd0);
        check("drain_ram_re", 64'(ram_re), 64'd0);
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: sampled at the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("sb_count", 64'(fifo_count), 64'(exp_q.size()));
            check("sb_wr_prdy", 64'(wr_prdy), 64'(exp_q.size() != 512));
            check("sb_same_addr", 64'(ram_we && ram_re && (ram_wa == ram_ra)), 64'd0);
            if (exp_q.size() == 0) check("sb_empty_no_valid", 64'(rd_pvld), 64'd0);
            if (rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    check("sb_pop_underflow", 64'd1, 64'd0);
                end else begin
                    check("sb_pop_data", rd_pd, exp_q.pop_front());
                end
            end
            if (wr_pvld && wr_prdy) exp_q.push_back(wr_pd);
        end
    end

    initial begin
        rst_n         = 1'b0;
        wr_pvld       = 1'b0;
        wr_pd         = 64'd0;
        rd_prdy       = 1'b0;
        pwrbus_ram_pd = 32'hA5A5_1234;

        // Reset values
        #2;
        check("rst_wr_prdy", 64'(wr_prdy), 64'd1);
        check("rst_rd_pvld", 64'(rd_pvld), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_re", 64'(ram_re), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_idle", 64'(fifo_idle), 64'd1);
        check("pwrbus", 64'(ram_pwrbus_ram_pd), 64'h0000_0000_A5A5_1234);
        wr_pvld = 1'b1;
        #1;
        check("rst_idle_follows", 64'(fifo_idle), 64'd0);
        check("rst_we_gated", 64'(ram_we), 64'd0);
        wr_pvld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single push latency
        wr_pvld = 1'b1;
        wr_pd   = 64'hDEAD_BEEF_0000_0001;
        rd_prdy = 1'b1;
        #1;
        check("p1_we", 64'(ram_we), 64'd1);
        check("p1_wa", 64'(ram_wa), 64'd0);
        check("p1_di", ram_di, 64'hDEAD_BEEF_0000_0001);
        check("p1_no_re", 64'(ram_re), 64'd0);
        tick();
        wr_pvld = 1'b0;
        #1;
        check("p1_n1_count", 64'(fifo_count), 64'd1);
        check("p1_n1_rd_pvld", 64'(rd_pvld), 64'd0);
        check("p1_n1_re", 64'(ram_re), 64'd1);
        check("p1_n1_ra", 64'(ram_ra), 64'd0);
        tick();
        check("p1_n2_rd_pvld", 64'(rd_pvld), 64'd1);
        check("p1_n2_rd_pd", rd_pd, 64'hDEAD_BEEF_0000_0001);
        tick();
        check("p1_n3_rd_pvld", 64'(rd_pvld), 64'd0);
        check("p1_n3_count", 64'(fifo_count), 64'd0);

        // Fill to 512 with reads blocked
        rd_prdy = 1'b0;
        for (int i = 0; i < 512; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'h1000 + 64'(i);
            tick();
        end
        wr_pd = 64'hBAD_BAD;
        rd_prdy = 1'b1;
        #1;
        check("full_count", 64'(fifo_count), 64'd512);
        check("full_wr_prdy", 64'(wr_prdy), 64'd0);
        check("full_we", 64'(ram_we), 64'd0);
        check("full_rd_pd", rd_pd, 64'h1000);
        tick();
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        #1;
        check("after_pop_wr_prdy", 64'(wr_prdy), 64'd1);
        check("after_pop_count", 64'(fifo_count), 64'd511);
        check("after_pop_rd_pvld", 64'(rd_pvld), 64'd1);
        check("after_pop_rd_pd", rd_pd, 64'h1001);
        drain(600);

        // Output stall for 10 cycles
        rd_prdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'hA0 + 64'(i);
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_rd_pvld", 64'(rd_pvld), 64'd1);
            check("stall_rd_pd", rd_pd, 64'hA0);
            check("stall_re", 64'(ram_re), 64'd0);
            tick();
        end
        check("stall_count", 64'(fifo_count), 64'd3);
        drain(20);

        // Continuous stream across several pointer wraps
        for (int i = 0; i < 1500; i++) begin
            wr_pvld = 1'b1;
            rd_prdy = 1'b1;
            wr_pd   = 64'h0100_0000_0000_0000 + 64'(i);
            if (i >= 2) begin
                check("stream_no_bubble", 64'(rd_pvld), 64'd1);
                check("stream_count", 64'(fifo_count), 64'd2);
            end
            tick();
        end
        drain(10);

        // Asynchronous reset with 37 entries held
        rd_prdy = 1'b0;
        for (int i = 0; i < 37; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'hC0DE_0000_0000_0000 + 64'(i);
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        check("pre_rst_count", 64'(fifo_count), 64'd37);
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(fifo_count), 64'd0);
        check("arst_rd_pvld", 64'(rd_pvld), 64'd0);
        check("arst_wr_prdy", 64'(wr_prdy), 64'd1);
        check("arst_re", 64'(ram_re), 64'd0);
        check("arst_we", 64'(ram_we), 64'd0);
        check("arst_idle", 64'(fifo_idle), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rd_pvld", 64'(rd_pvld), 64'd0);
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        wr_pd   = 64'h5555_AAAA_5555_AAAA;
        tick();
        wr_pvld = 1'b0;
        check("post_rst_no_stale", 64'(rd_pvld), 64'd0);
        tick();
        check("post_rst_rd_pvld2", 64'(rd_pvld), 64'd1);
        check("post_rst_rd_pd", rd_pd, 64'h5555_AAAA_5555_AAAA);
        tick();
        check("post_rst_count", 64'(fifo_count), 64'd0);

        // Random traffic; payload and count checks come from the scoreboard
        for (int i = 0; i < 4000; i++) begin
            wr_pvld = 1'($urandom_range(0, 3) != 0);
            rd_prdy = 1'($urandom_range(0, 2) != 0);
            wr_pd   = {$urandom, $urandom};
            tick();
        end
        drain(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
